// File: rtl/dfc_sender_ctl.sv
// dfc_sender_ctl
//   Producer-side bridge from a srdy/drdy handshake to delayed flow control.
//   Incoming words go into a 2-entry skid buffer. They are launched as
//   registered c_vld/c_data whenever the delayed flow-control bit allows it.
//   c_fc_n passes through fc_delay register stages before it is used. While
//   those stages refill after a stop, the remote receiver FIFO holds the words
//   that were already in flight.
//
// Ports
//   clk        clock
//   reset      asynchronous, active-high reset
//   p_srdy     producer word valid
//   p_drdy     block can accept a word (registered)
//   p_data     producer word
//   c_vld      word launched this cycle (registered)
//   c_data     launched word (registered, holds between launches)
//   c_fc_n     receiver flow control, 1 = may send, 0 = stop
//   stat_clr   synchronous clear of both statistics counters
//   sent_cnt   words launched, saturating
//   stall_cnt  cycles with buffered data held by flow control, saturating
module dfc_sender_ctl #(
  parameter int unsigned width    = 8,
  parameter int unsigned fc_delay = 1,
  parameter int unsigned cnt_w    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             p_srdy,
  output logic             p_drdy,
  input  logic [width-1:0] p_data,
  output logic             c_vld,
  output logic [width-1:0] c_data,
  input  logic             c_fc_n,
  input  logic             stat_clr,
  output logic [cnt_w-1:0] sent_cnt,
  output logic [cnt_w-1:0] stall_cnt
);

  logic [fc_delay-1:0] fc_q;
  logic                fc_ok;

  logic [width-1:0]    mem [2];
  logic                head;
  logic                tail;
  logic [1:0]          count;
  logic [1:0]          count_next;

  logic                push;
  logic                pop;
  logic                stall;

  assign fc_ok = fc_q[fc_delay-1];
  assign push  = p_srdy & p_drdy;
  assign pop   = fc_ok & (count != 2'd0);
  assign stall = (count != 2'd0) & ~fc_ok;

  always_comb begin
    count_next = count + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fc_q      <= '0;
      mem[0]    <= '0;
      mem[1]    <= '0;
      head      <= 1'b0;
      tail      <= 1'b0;
      count     <= 2'd0;
      p_drdy    <= 1'b0;
      c_vld     <= 1'b0;
      c_data    <= '0;
      sent_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      fc_q[0] <= c_fc_n;
      for (int unsigned i = 1; i < fc_delay; i++) begin
        fc_q[i] <= fc_q[i-1];
      end

      if (push) begin
        mem[tail] <= p_data;
        tail      <= ~tail;
      end

      if (pop) begin
        head   <= ~head;
        c_vld  <= 1'b1;
        c_data <= mem[head];
      end else begin
        c_vld  <= 1'b0;
      end

      count <= count_next;
      // Computed from the next occupancy so p_drdy stays a plain flop output.
      p_drdy <= (count_next < 2'd2);

      if (stat_clr) begin
        sent_cnt <= '0;
      end else if (pop && (sent_cnt != '1)) begin
        sent_cnt <= sent_cnt + 1'b1;
      end

      if (stat_clr) begin
        stall_cnt <= '0;
      end else if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dfc_sender_ctl.sv
// Directed bench for dfc_sender_ctl. u0 uses the default parameters. u1 uses
// fc_delay=3 and cnt_w=4 to exercise the longer flow-control pipe and
// counter saturation.
module tb_dfc_sender_ctl;

  logic       clk;
  logic       reset;
  logic       stat_clr;

  logic       p_srdy, p_drdy, c_vld, c_fc_n;
  logic [7:0] p_data, c_data;
  logic [15:0] sent_cnt, stall_cnt;

  logic       p_srdy1, p_drdy1, c_vld1, c_fc_n1;
  logic [7:0] p_data1, c_data1;
  logic [3:0] sent_cnt1, stall_cnt1;

  int total = 0;
  int bad   = 0;

  dfc_sender_ctl #(.width(8), .fc_delay(1), .cnt_w(16)) u0 (
    .clk(clk), .reset(reset), .p_srdy(p_srdy), .p_drdy(p_drdy),
    .p_data(p_data), .c_vld(c_vld), .c_data(c_data), .c_fc_n(c_fc_n),
    .stat_clr(stat_clr), .sent_cnt(sent_cnt), .stall_cnt(stall_cnt)
  );

  dfc_sender_ctl #(.width(8), .fc_delay(3), .cnt_w(4)) u1 (
    .clk(clk), .reset(reset), .p_srdy(p_srdy1), .p_drdy(p_drdy1),
    .p_data(p_data1), .c_vld(c_vld1), .c_data(c_data1), .c_fc_n(c_fc_n1),
    .stat_clr(stat_clr), .sent_cnt(sent_cnt1), .stall_cnt(stall_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic e0(input string tag, input logic vld, input logic [7:0] data, input logic drdy);
    chk({tag, "_vld"}, c_vld, vld);
    chk({tag, "_data"}, c_data, data);
    chk({tag, "_drdy"}, p_drdy, drdy);
  endtask

  task automatic e1(input string tag, input logic vld, input logic [7:0] data, input logic drdy);
    chk({tag, "_vld1"}, c_vld1, vld);
    chk({tag, "_data1"}, c_data1, data);
    chk({tag, "_drdy1"}, p_drdy1, drdy);
  endtask

  initial begin
    reset = 1'b1; stat_clr = 1'b0;
    p_srdy = 1'b0; p_data = '0; c_fc_n = 1'b1;
    p_srdy1 = 1'b0; p_data1 = '0; c_fc_n1 = 1'b1;
    #2;
    e0("rst", 1'b0, 8'h00, 1'b0);
    chk("rst_sent", sent_cnt, 0);
    chk("rst_stall", stall_cnt, 0);
    e1("rst", 1'b0, 8'h00, 1'b0);
    @(posedge clk);
    #3 reset = 1'b0;

    // single word latency
    step();
    e0("t1_e1", 1'b0, 8'h00, 1'b1);
    p_srdy = 1'b1; p_data = 8'hA5;
    step();
    e0("t1_e2", 1'b0, 8'h00, 1'b1);
    p_srdy = 1'b0;
    step();
    e0("t1_e3", 1'b1, 8'hA5, 1'b1);
    chk("t1_sent", sent_cnt, 1);
    step();
    e0("t1_e4", 1'b0, 8'hA5, 1'b1);

    // streaming 20 words, push and pop together at count 1
    p_srdy = 1'b1; p_data = 8'd0;
    for (int k = 0; k < 22; k++) begin
      step();
      chk("t2_vld", c_vld, (k >= 1 && k <= 20));
      if (k >= 1 && k <= 20) chk("t2_data", c_data, k - 1);
      chk("t2_drdy", p_drdy, 1);
      p_data = 8'(k + 1);
      p_srdy = (k + 1 < 20);
    end
    chk("t2_sent", sent_cnt, 21);
    chk("t2_stall", stall_cnt, 0);

    // stop mid-stream, skid fills, resume
    p_srdy = 1'b1; p_data = 8'h30;
    step(); e0("t3_e1", 1'b0, 8'd19, 1'b1);
    p_data = 8'h31;
    step(); e0("t3_e2", 1'b1, 8'h30, 1'b1);
    p_data = 8'h32; c_fc_n = 1'b0;
    step(); e0("t3_e3", 1'b1, 8'h31, 1'b1);
    p_data = 8'h33;
    step(); e0("t3_e4", 1'b0, 8'h31, 1'b0);
    chk("t3_stall4", stall_cnt, 1);
    p_data = 8'h34;
    step(); e0("t3_e5", 1'b0, 8'h31, 1'b0);
    step(); e0("t3_e6", 1'b0, 8'h31, 1'b0);
    c_fc_n = 1'b1;
    step(); e0("t3_e7", 1'b0, 8'h31, 1'b0);
    chk("t3_stall7", stall_cnt, 4);
    step(); e0("t3_e8", 1'b1, 8'h32, 1'b1);
    step(); e0("t3_e9", 1'b1, 8'h33, 1'b1);
    p_srdy = 1'b0;
    step(); e0("t3_e10", 1'b1, 8'h34, 1'b1);
    step(); e0("t3_e11", 1'b0, 8'h34, 1'b1);
    chk("t3_sent", sent_cnt, 26);
    chk("t3_stall", stall_cnt, 4);

    stat_clr = 1'b1;
    step();
    chk("clr_sent", sent_cnt, 0);
    chk("clr_stall", stall_cnt, 0);
    stat_clr = 1'b0;

    // async reset with a launch on the output and a word buffered
    c_fc_n = 1'b0;
    step();
    p_srdy = 1'b1; p_data = 8'h50;
    step(); e0("t6_a", 1'b0, 8'h34, 1'b1);
    p_data = 8'h51;
    step(); e0("t6_b", 1'b0, 8'h34, 1'b0);
    p_srdy = 1'b0; c_fc_n = 1'b1;
    step();
    step(); e0("t6_c", 1'b1, 8'h50, 1'b1);
    #2 reset = 1'b1;
    #1;
    e0("t6_rst", 1'b0, 8'h00, 1'b0);
    chk("t6_sent", sent_cnt, 0);
    @(posedge clk);
    #3 reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      e0("t6_post", 1'b0, 8'h00, 1'b1);
    end

    // u1: stop latency with three flow-control stages
    p_srdy1 = 1'b1; p_data1 = 8'h60; c_fc_n1 = 1'b0;
    step(); e1("u1_f1", 1'b0, 8'h00, 1'b1);
    p_data1 = 8'h61;
    step(); e1("u1_f2", 1'b1, 8'h60, 1'b1);
    p_data1 = 8'h62;
    step(); e1("u1_f3", 1'b1, 8'h61, 1'b1);
    p_data1 = 8'h63;
    step(); e1("u1_f4", 1'b0, 8'h61, 1'b0);
    chk("u1_stall_f4", stall_cnt1, 1);
    p_srdy1 = 1'b0; c_fc_n1 = 1'b1;
    step(); e1("u1_g1", 1'b0, 8'h61, 1'b0);
    step(); e1("u1_g2", 1'b0, 8'h61, 1'b0);
    step(); e1("u1_g3", 1'b0, 8'h61, 1'b0);
    chk("u1_stall_g3", stall_cnt1, 4);
    step(); e1("u1_g4", 1'b1, 8'h62, 1'b1);
    step(); e1("u1_g5", 1'b1, 8'h63, 1'b1);
    step(); e1("u1_g6", 1'b0, 8'h63, 1'b1);
    chk("u1_sent4", sent_cnt1, 4);

    // u1: saturation of the 4-bit sent counter
    p_srdy1 = 1'b1; p_data1 = 8'd0;
    for (int k = 0; k < 22; k++) begin
      step();
      chk("u1_s_vld", c_vld1, (k >= 1 && k <= 20));
      if (k >= 1 && k <= 20) chk("u1_s_data", c_data1, k - 1);
      p_data1 = 8'(k + 1);
      p_srdy1 = (k + 1 < 20);
    end
    chk("u1_sat", sent_cnt1, 15);

    // clear wins over a pop in the same cycle
    p_srdy1 = 1'b1; p_data1 = 8'h77;
    step(); e1("u1_c1", 1'b0, 8'd19, 1'b1);
    p_srdy1 = 1'b0; stat_clr = 1'b1;
    step(); e1("u1_c2", 1'b1, 8'h77, 1'b1);
    chk("u1_clr_sent", sent_cnt1, 0);
    chk("u1_clr_stall", stall_cnt1, 0);
    stat_clr = 1'b0;
    step();
    chk("u1_after_clr", sent_cnt1, 0);
    chk("u1_after_vld", c_vld1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
